secksa_sched: RTL and testbench
===============================

SECKSA_SCHED -- requirements
Module: secksa_sched

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_SHARES, 3, Boolean shares per operand.
- K, 32, Operand width per share.
- RND_W, 960, Fresh-randomness bits per adder operation.
- TAG_DEPTH, 8, Maximum in-flight adder operations; power of two, at least 2.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i, in, 1, Single clock.
- rst_ni, in, 1, Asynchronous active-low reset.
- i_req0_vld / o_req0_rdy, in / out, 1 each, Requester-0 handshake.
- i_req0_x, i_req0_y, in, N_SHARES*K each, Requester-0 shared operands; share s is at [s*K +: K].
- i_req1_vld / o_req1_rdy, i_req1_x, i_req1_y, as requester 0, Requester-1 port.
- i_rnd_vld / o_rnd_rdy, in / out, 1 each, Randomness handshake.
- i_rnd, in, RND_W, Fresh randomness.
- o_ksa_dvld, out, 1, Operand-valid strobe to the adder.
- o_ksa_rvld, out, 1, Randomness-valid strobe to the adder.
- o_ksa_x, o_ksa_y, out, N_SHARES*K each, Operands to the adder.
- o_ksa_n, out, RND_W, Randomness to the adder.
- i_ksa_z, in, N_SHARES*K, Adder result.
- i_ksa_dvld, in, 1, Adder result-valid strobe.
- o_rsp0_vld, o_rsp0_z, out, 1 / N_SHARES*K, Requester-0 result.
- o_rsp1_vld, o_rsp1_z, out, 1 / N_SHARES*K, Requester-1 result.
- o_busy, out, 1, At least one operation is in flight.
- o_err, out, 1, Sticky protocol error.

Function
REQ-003 Issue condition: (i_req0_vld | i_req1_vld) & i_rnd_vld & tag FIFO not full, with fullness evaluated before any same-cycle pop.
REQ-004 Arbitration SHALL be two-way round robin.
- Pointer rr resets to 0.
- If both requesters are valid, grant requester rr; if only one is valid, grant that one.
- On every issue, rr becomes the complement of the granted index.
REQ-005 On issue, the granted o_reqN_rdy and o_rnd_rdy SHALL be asserted combinationally in that same cycle; all other rdy outputs are 0.
REQ-006 Randomness SHALL be consumed exactly once: each accepted i_rnd word feeds exactly one operation and is never reused.
REQ-007 The cycle after an issue:
- o_ksa_dvld = o_ksa_rvld = 1 for exactly one cycle.
- o_ksa_x, o_ksa_y and o_ksa_n carry the registered granted operands and randomness.
REQ-008 In cycles with no issue strobe, o_ksa_x, o_ksa_y and o_ksa_n SHALL be driven all-zero.
REQ-009 Shares SHALL be routed bit-exact; no logic may combine two shares of the same value.
REQ-010 On issue, the grant index SHALL be pushed into a TAG_DEPTH-entry tag FIFO; issue order equals completion order.
REQ-011 On i_ksa_dvld with the FIFO non-empty:
- The FIFO is popped.
- One cycle later, o_rspT_vld = 1 for exactly one cycle and o_rspT_z = registered i_ksa_z, where T is the popped tag.
- The other response port stays at vld = 0.
REQ-012 The response path has no backpressure. o_rspN_z SHALL be all-zero whenever o_rspN_vld = 0.
REQ-013 i_ksa_dvld with the FIFO empty SHALL set o_err (sticky) and produce no response.
REQ-014 A same-cycle push and pop SHALL leave the FIFO count unchanged. Read/write pointers are log2(TAG_DEPTH) bits plus a wrap bit and wrap modulo TAG_DEPTH.
REQ-015 o_busy = (FIFO count != 0), registered.
REQ-016 End-to-end latency = 1 cycle (issue register) + adder latency + 1 cycle (response register).

Reset
REQ-017 Assertion of rst_ni low SHALL immediately clear all of the following:
- rr, FIFO pointers and count.
- o_err and o_busy.
- All vld/rdy strobes.
- All data outputs, to zero.
REQ-018 In-flight operations SHALL be discarded on reset mid-operation. A later i_ksa_dvld with an empty FIFO raises o_err per REQ-013.
REQ-019 No issue SHALL occur in the first cycle after rst_ni deasserts; arbitration starts on the following edge.

Verification
REQ-020 Single op: req0 x shares {A,B,C}, y shares {D,E,F}, rnd valid; model adder computes (A^B^C)+(D^E^F) -> o_rsp0_vld pulses once; XOR of o_rsp0_z shares equals the model sum.
REQ-021 Contention: both requesters valid for 6 back-to-back cycles with rnd always valid -> grants alternate 0,1,0,1,0,1; responses return in the same order.
REQ-022 Randomness starvation: i_rnd_vld = 0 for 5 cycles while req0 is valid -> no rdy asserted and o_ksa_dvld = 0 throughout; issue occurs in the first cycle i_rnd_vld = 1.
REQ-023 Full FIFO: TAG_DEPTH = 8 with the adder holding all results -> exactly 8 issues, then rdy = 0; a ninth issue follows the first i_ksa_dvld.
REQ-024 Error: i_ksa_dvld pulse after reset with nothing issued -> o_err = 1 and stays 1 until reset; no o_rsp vld.
REQ-025 Reset mid-flight: 3 issued, reset pulsed -> o_busy = 0, all outputs zero, rr = 0.

Source files
------------

// File: rtl/secksa_sched.sv
// secksa_sched: issue/response scheduler in front of a masked (Boolean-shared)
// Kogge-Stone adder shared by two requesters.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   i_reqN_vld / o_reqN_rdy       requester N handshake (N = 0, 1)
//   i_reqN_x, i_reqN_y            requester N shared operands, share s at [s*K +: K]
//   i_rnd_vld / o_rnd_rdy, i_rnd  fresh-randomness handshake and word
//   o_ksa_dvld, o_ksa_rvld        one-cycle operand / randomness strobes to the adder
//   o_ksa_x, o_ksa_y, o_ksa_n     registered operands and randomness (zero when idle)
//   i_ksa_z, i_ksa_dvld           adder result and its valid strobe
//   o_rspN_vld, o_rspN_z          requester N result pulse (z is zero when vld = 0)
//   o_busy                        at least one operation in flight
//   o_err                         sticky: adder result arrived with nothing in flight
//
// Handshake: a transfer on a requester or randomness port happens in the cycle
// its rdy is high; rdy is only ever high together with vld, so there is no
// separate "fire" condition. Responses carry no backpressure.
module secksa_sched #(
    parameter int N_SHARES  = 3,
    parameter int K         = 32,
    parameter int RND_W     = 960,
    parameter int TAG_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_req0_vld,
    output logic                  o_req0_rdy,
    input  logic [N_SHARES*K-1:0] i_req0_x,
    input  logic [N_SHARES*K-1:0] i_req0_y,
    input  logic                  i_req1_vld,
    output logic                  o_req1_rdy,
    input  logic [N_SHARES*K-1:0] i_req1_x,
    input  logic [N_SHARES*K-1:0] i_req1_y,
    input  logic                  i_rnd_vld,
    output logic                  o_rnd_rdy,
    input  logic [RND_W-1:0]      i_rnd,
    output logic                  o_ksa_dvld,
    output logic                  o_ksa_rvld,
    output logic [N_SHARES*K-1:0] o_ksa_x,
    output logic [N_SHARES*K-1:0] o_ksa_y,
    output logic [RND_W-1:0]      o_ksa_n,
    input  logic [N_SHARES*K-1:0] i_ksa_z,
    input  logic                  i_ksa_dvld,
    output logic                  o_rsp0_vld,
    output logic [N_SHARES*K-1:0] o_rsp0_z,
    output logic                  o_rsp1_vld,
    output logic [N_SHARES*K-1:0] o_rsp1_z,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int DW = N_SHARES * K;
    localparam int PW = $clog2(TAG_DEPTH);

    // State registers
    logic                 arm_q,      arm_d;
    logic                 rr_q,       rr_d;
    logic                 ksa_vld_q,  ksa_vld_d;
    logic [DW-1:0]        ksa_x_q,    ksa_x_d;
    logic [DW-1:0]        ksa_y_q,    ksa_y_d;
    logic [RND_W-1:0]     ksa_n_q,    ksa_n_d;
    logic [PW:0]          wptr_q,     wptr_d;
    logic [PW:0]          rptr_q,     rptr_d;
    logic [TAG_DEPTH-1:0] tag_q,      tag_d;
    logic                 rsp0_vld_q, rsp0_vld_d;
    logic                 rsp1_vld_q, rsp1_vld_d;
    logic [DW-1:0]        rsp0_z_q,   rsp0_z_d;
    logic [DW-1:0]        rsp1_z_q,   rsp1_z_d;
    logic                 busy_q,     busy_d;
    logic                 err_q,      err_d;

    // Combinational helpers
    logic        fifo_full;
    logic        fifo_empty;
    logic [PW:0] count;
    logic [PW:0] count_nxt;
    logic        issue;
    logic        gnt;
    logic        pop;
    logic        pop_tag;

    // Occupancy comes from the pointer difference; the extra wrap bit lets a
    // full FIFO be told apart from an empty one.
    assign count      = wptr_q - rptr_q;
    assign fifo_full  = (count == (PW+1)'(TAG_DEPTH));
    assign fifo_empty = (count == '0);

    // arm_q holds issue off for the first cycle after reset release.
    assign issue = arm_q & (i_req0_vld | i_req1_vld) & i_rnd_vld & ~fifo_full;

    // Both valid: take the round-robin pointer; otherwise the lone requester.
    assign gnt = (i_req0_vld & i_req1_vld) ? rr_q : ~i_req0_vld;

    assign pop     = i_ksa_dvld & ~fifo_empty;
    assign pop_tag = tag_q[rptr_q[PW-1:0]];

    assign o_req0_rdy = issue & ~gnt;
    assign o_req1_rdy = issue & gnt;
    assign o_rnd_rdy  = issue;

    always_comb begin
        arm_d      = 1'b1;
        rr_d       = rr_q;
        ksa_vld_d  = issue;
        ksa_x_d    = '0;
        ksa_y_d    = '0;
        ksa_n_d    = '0;
        tag_d      = tag_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rsp0_vld_d = 1'b0;
        rsp1_vld_d = 1'b0;
        rsp0_z_d   = '0;
        rsp1_z_d   = '0;
        err_d      = err_q | (i_ksa_dvld & fifo_empty);

        if (issue) begin
            rr_d    = ~gnt;
            // Shares are moved as whole vectors; nothing combines them.
            ksa_x_d = gnt ? i_req1_x : i_req0_x;
            ksa_y_d = gnt ? i_req1_y : i_req0_y;
            ksa_n_d = i_rnd;
            tag_d[wptr_q[PW-1:0]] = gnt;
            wptr_d  = wptr_q + {{PW{1'b0}}, 1'b1};
        end

        if (pop) begin
            rptr_d = rptr_q + {{PW{1'b0}}, 1'b1};
            if (pop_tag) begin
                rsp1_vld_d = 1'b1;
                rsp1_z_d   = i_ksa_z;
            end else begin
                rsp0_vld_d = 1'b1;
                rsp0_z_d   = i_ksa_z;
            end
        end

        count_nxt = wptr_d - rptr_d;
        busy_d    = (count_nxt != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arm_q      <= 1'b0;
            rr_q       <= 1'b0;
            ksa_vld_q  <= 1'b0;
            ksa_x_q    <= '0;
            ksa_y_q    <= '0;
            ksa_n_q    <= '0;
            tag_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            rsp0_z_q   <= '0;
            rsp1_z_q   <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            arm_q      <= arm_d;
            rr_q       <= rr_d;
            ksa_vld_q  <= ksa_vld_d;
            ksa_x_q    <= ksa_x_d;
            ksa_y_q    <= ksa_y_d;
            ksa_n_q    <= ksa_n_d;
            tag_q      <= tag_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rsp0_vld_q <= rsp0_vld_d;
            rsp1_vld_q <= rsp1_vld_d;
            rsp0_z_q   <= rsp0_z_d;
            rsp1_z_q   <= rsp1_z_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign o_ksa_dvld = ksa_vld_q;
    assign o_ksa_rvld = ksa_vld_q;
    assign o_ksa_x    = ksa_x_q;
    assign o_ksa_y    = ksa_y_q;
    assign o_ksa_n    = ksa_n_q;
    assign o_rsp0_vld = rsp0_vld_q;
    assign o_rsp0_z   = rsp0_z_q;
    assign o_rsp1_vld = rsp1_vld_q;
    assign o_rsp1_z   = rsp1_z_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_secksa_sched.sv
// Testbench for secksa_sched: directed scenarios plus a randomized phase, all
// checked every cycle against a queue-based behavioural model of the scheduler
// and a behavioural masked adder.
module tb_secksa_sched;

    localparam int NS = 3;
    localparam int K  = 32;
    localparam int RW = 960;
    localparam int TD = 8;
    localparam int DW = NS * K;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          i_req0_vld, i_req1_vld, i_rnd_vld, i_ksa_dvld;
    logic          o_req0_rdy, o_req1_rdy, o_rnd_rdy;
    logic [DW-1:0] i_req0_x, i_req0_y, i_req1_x, i_req1_y, i_ksa_z;
    logic [RW-1:0] i_rnd;
    logic          o_ksa_dvld, o_ksa_rvld;
    logic [DW-1:0] o_ksa_x, o_ksa_y;
    logic [RW-1:0] o_ksa_n;
    logic          o_rsp0_vld, o_rsp1_vld;
    logic [DW-1:0] o_rsp0_z, o_rsp1_z;
    logic          o_busy, o_err;

    always #5 clk_i = ~clk_i;

    secksa_sched #(.N_SHARES(NS), .K(K), .RND_W(RW), .TAG_DEPTH(TD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .i_req0_vld(i_req0_vld), .o_req0_rdy(o_req0_rdy), .i_req0_x(i_req0_x), .i_req0_y(i_req0_y),
        .i_req1_vld(i_req1_vld), .o_req1_rdy(o_req1_rdy), .i_req1_x(i_req1_x), .i_req1_y(i_req1_y),
        .i_rnd_vld(i_rnd_vld), .o_rnd_rdy(o_rnd_rdy), .i_rnd(i_rnd),
        .o_ksa_dvld(o_ksa_dvld), .o_ksa_rvld(o_ksa_rvld),
        .o_ksa_x(o_ksa_x), .o_ksa_y(o_ksa_y), .o_ksa_n(o_ksa_n),
        .i_ksa_z(i_ksa_z), .i_ksa_dvld(i_ksa_dvld),
        .o_rsp0_vld(o_rsp0_vld), .o_rsp0_z(o_rsp0_z),
        .o_rsp1_vld(o_rsp1_vld), .o_rsp1_z(o_rsp1_z),
        .o_busy(o_busy), .o_err(o_err)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: in-flight tags in issue order, expected adder results
    // in issue order, and what the registered outputs must show this cycle.
    int            rr_m;
    bit            armed_m;
    int            tagq[$];
    logic [DW-1:0] exp_q[$];
    bit            ksa_m;
    logic [DW-1:0] ksa_x_m, ksa_y_m;
    logic [RW-1:0] ksa_n_m;
    bit            rsp_vld_m [2];
    logic [DW-1:0] rsp_z_m [2];
    bit            err_m;

    // Observation logs
    int            gnt_log[$];
    int            rsp_log[$];
    int            rsp_cnt [2];
    int            issue_cnt;
    int            ksa_cnt;
    logic [DW-1:0] last_rsp0;
    bit            hold_data;

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] v;
        for (int i = 0; i < NS; i++) v[i*K +: K] = $urandom();
        return v;
    endfunction

    function automatic logic [RW-1:0] rand_rw();
        logic [RW-1:0] v;
        for (int i = 0; i < RW/32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [K-1:0] unshare(input logic [DW-1:0] v);
        logic [K-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) r = r ^ v[i*K +: K];
        return r;
    endfunction

    // Masked adder: unmasked sum, re-shared with fresh random masks.
    function automatic logic [DW-1:0] adder(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW-1:0] r;
        logic [K-1:0]  acc;
        acc = unshare(x) + unshare(y);
        for (int i = 0; i < NS-1; i++) begin
            r[i*K +: K] = $urandom();
            acc = acc ^ r[i*K +: K];
        end
        r[(NS-1)*K +: K] = acc;
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_n(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < RW/32; i++) begin
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
                    $display("FAIL %s: word %0d got %h expected %h at %0t", name, i,
                             act[i*32 +: 32], exp[i*32 +: 32], $time);
                    break;
                end
            end
        end
    endtask

    task automatic model_clear();
        rr_m = 0;
        armed_m = 0;
        tagq.delete();
        exp_q.delete();
        ksa_m = 0;
        ksa_x_m = '0;
        ksa_y_m = '0;
        ksa_n_m = '0;
        for (int i = 0; i < 2; i++) begin
            rsp_vld_m[i] = 0;
            rsp_z_m[i] = '0;
        end
        err_m = 0;
    endtask

    // Asserts reset mid-cycle, checks every output is cleared at once, then
    // releases reset on a falling edge so the next cycle() covers the first
    // rising edge after release.
    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        chk1("rst_req0_rdy", o_req0_rdy, 1'b0);
        chk1("rst_req1_rdy", o_req1_rdy, 1'b0);
        chk1("rst_rnd_rdy", o_rnd_rdy, 1'b0);
        chk1("rst_ksa_dvld", o_ksa_dvld, 1'b0);
        chk1("rst_ksa_rvld", o_ksa_rvld, 1'b0);
        chk("rst_ksa_x", o_ksa_x, '0);
        chk("rst_ksa_y", o_ksa_y, '0);
        chk_n("rst_ksa_n", o_ksa_n, '0);
        chk1("rst_rsp0_vld", o_rsp0_vld, 1'b0);
        chk("rst_rsp0_z", o_rsp0_z, '0);
        chk1("rst_rsp1_vld", o_rsp1_vld, 1'b0);
        chk("rst_rsp1_z", o_rsp1_z, '0);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_err", o_err, 1'b0);
        i_req0_vld = 0; i_req1_vld = 0; i_rnd_vld = 0; i_ksa_dvld = 0;
        model_clear();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare every DUT
    // output with the model, then advance the model across the rising edge.
    task automatic cycle(input bit v0, input bit v1, input bit vr, input bit kd);
        bit            iss;
        int            g;
        int            t;
        logic [DW-1:0] zin;
        if (!hold_data) begin
            i_req0_x = rand_dw(); i_req0_y = rand_dw();
            i_req1_x = rand_dw(); i_req1_y = rand_dw();
            i_rnd    = rand_rw();
        end
        zin = (kd && exp_q.size() > 0) ? exp_q[0] : rand_dw();
        i_req0_vld = v0; i_req1_vld = v1; i_rnd_vld = vr;
        i_ksa_dvld = kd; i_ksa_z = zin;
        #1;
        iss = armed_m && (v0 || v1) && vr && (tagq.size() < TD);
        g   = (v0 && v1) ? rr_m : (v0 ? 0 : 1);
        chk1("req0_rdy", o_req0_rdy, iss && g == 0);
        chk1("req1_rdy", o_req1_rdy, iss && g == 1);
        chk1("rnd_rdy", o_rnd_rdy, iss);
        chk1("ksa_dvld", o_ksa_dvld, ksa_m);
        chk1("ksa_rvld", o_ksa_rvld, ksa_m);
        chk("ksa_x", o_ksa_x, ksa_x_m);
        chk("ksa_y", o_ksa_y, ksa_y_m);
        chk_n("ksa_n", o_ksa_n, ksa_n_m);
        chk1("rsp0_vld", o_rsp0_vld, rsp_vld_m[0]);
        chk("rsp0_z", o_rsp0_z, rsp_z_m[0]);
        chk1("rsp1_vld", o_rsp1_vld, rsp_vld_m[1]);
        chk("rsp1_z", o_rsp1_z, rsp_z_m[1]);
        chk1("busy", o_busy, tagq.size() != 0);
        chk1("err", o_err, err_m);

        if (o_req0_rdy) gnt_log.push_back(0);
        if (o_req1_rdy) gnt_log.push_back(1);
        if (o_req0_rdy || o_req1_rdy) issue_cnt++;
        if (o_ksa_dvld) ksa_cnt++;
        if (o_rsp0_vld) begin rsp_log.push_back(0); rsp_cnt[0]++; last_rsp0 = o_rsp0_z; end
        if (o_rsp1_vld) begin rsp_log.push_back(1); rsp_cnt[1]++; end

        for (int i = 0; i < 2; i++) begin
            rsp_vld_m[i] = 0;
            rsp_z_m[i] = '0;
        end
        if (kd) begin
            if (tagq.size() > 0) begin
                t = tagq.pop_front();
                rsp_vld_m[t] = 1;
                rsp_z_m[t] = zin;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                err_m = 1;
            end
        end
        if (ksa_m) exp_q.push_back(adder(ksa_x_m, ksa_y_m));
        ksa_m = iss;
        if (iss) begin
            ksa_x_m = g ? i_req1_x : i_req0_x;
            ksa_y_m = g ? i_req1_y : i_req0_y;
            ksa_n_m = i_rnd;
            tagq.push_back(g);
            rr_m = 1 - g;
        end else begin
            ksa_x_m = '0;
            ksa_y_m = '0;
            ksa_n_m = '0;
        end
        armed_m = 1;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        rsp_log.delete();
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;
        issue_cnt = 0;
        ksa_cnt = 0;
    endtask

    initial begin
        int pat [6];
        logic [DW-1:0] xa, ya;
        pat = '{0, 1, 0, 1, 0, 1};
        rst_ni = 1'b1;
        hold_data = 0;
        i_req0_vld = 0; i_req1_vld = 0; i_rnd_vld = 0; i_ksa_dvld = 0;
        i_req0_x = '0; i_req0_y = '0; i_req1_x = '0; i_req1_y = '0;
        i_rnd = '0; i_ksa_z = '0; last_rsp0 = '0;
        clear_logs();
        model_clear();
        @(negedge clk_i);
        do_reset();

        // Single operation with hand-picked shares: (1^2^4) + (8^16^32) = 63.
        xa = {32'h4, 32'h2, 32'h1};
        ya = {32'h20, 32'h10, 32'h8};
        chk("model_sum_pin", {64'd0, unshare(adder(xa, ya))}, 96'd63);
        hold_data = 1;
        i_req0_x = xa; i_req0_y = ya;
        i_req1_x = rand_dw(); i_req1_y = rand_dw(); i_rnd = rand_rw();
        clear_logs();
        cycle(1, 0, 1, 0);          // first cycle after release: must not issue
        chk_int("no_issue_after_reset", issue_cnt, 0);
        cycle(1, 0, 1, 0);
        hold_data = 0;
        idle(1);
        cycle(0, 0, 0, 1);
        idle(2);
        chk_int("single_rsp0_count", rsp_cnt[0], 1);
        chk_int("single_rsp1_count", rsp_cnt[1], 0);
        chk("single_rsp_xor", {64'd0, unshare(last_rsp0)}, 96'd63);

        // Contention: six back-to-back cycles with both requesters valid.
        do_reset();
        idle(1);
        clear_logs();
        for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0);
        idle(2);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
        idle(1);
        chk_int("contention_grants", gnt_log.size(), 6);
        chk_int("contention_rsps", rsp_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk_int("grant_order", (i < gnt_log.size()) ? gnt_log[i] : 99, pat[i]);
            chk_int("rsp_order", (i < rsp_log.size()) ? rsp_log[i] : 99, pat[i]);
        end

        // Randomness starvation.
        do_reset();
        idle(1);
        clear_logs();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        chk_int("starve_issues", issue_cnt, 0);
        chk_int("starve_ksa", ksa_cnt, 0);
        cycle(1, 0, 1, 0);
        chk_int("starve_release", issue_cnt, 1);
        idle(1);
        cycle(0, 0, 0, 1);
        idle(1);

        // Full tag FIFO: adder holds every result.
        do_reset();
        idle(1);
        clear_logs();
        for (int i = 0; i < 12; i++) cycle(1, 1, 1, 0);
        chk_int("full_issues", issue_cnt, 8);
        cycle(1, 1, 1, 1);          // pop does not free the slot this cycle
        chk_int("full_same_cycle", issue_cnt, 8);
        cycle(1, 0, 1, 0);
        chk_int("full_ninth", issue_cnt, 9);
        idle(1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);
        idle(1);
        chk_int("full_rsps", rsp_cnt[0] + rsp_cnt[1], 9);

        // Spurious adder result with nothing in flight.
        do_reset();
        idle(1);
        clear_logs();
        cycle(0, 0, 0, 1);
        idle(4);
        chk1("err_sticky", o_err, 1'b1);
        chk_int("err_no_rsp", rsp_cnt[0] + rsp_cnt[1], 0);

        // Reset with three operations in flight.
        do_reset();
        idle(1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0);
        idle(1);
        chk1("midflight_busy", o_busy, 1'b1);
        do_reset();
        idle(1);
        clear_logs();
        cycle(1, 1, 1, 0);
        chk_int("rr_after_reset", (gnt_log.size() > 0) ? gnt_log[0] : 99, 0);
        idle(1);
        cycle(0, 0, 0, 1);
        idle(1);
        cycle(0, 0, 0, 1);          // nothing left: discarded ops must not answer
        idle(1);
        chk1("discard_err", o_err, 1'b1);
        chk_int("discard_rsps", rsp_cnt[0] + rsp_cnt[1], 1);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  exp_q.size() > 0 && $urandom_range(0, 2) != 0);
        end
        idle(2);
        while (exp_q.size() > 0) cycle(0, 0, 0, 1);
        idle(2);
        chk1("random_drained_busy", o_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
